i2c_scl_gen: RTL and testbench
==============================

Name: i2c_scl_gen

Overview:
Parametrised SCL generator for the APB I2C master. It replaces the single-toggle flop generator with a programmable half-period counter, and adds pause (TWINT-style hold-low), slave clock stretching and multi-master clock synchronisation. It drives the open-drain SCL pad enable and provides edge and sample strobes to the byte/bit controller.

Parameters:
DIV_WIDTH, 16, width of the half-period divider value and the internal phase counter
SYNC_STAGES, 2, number of synchroniser flops on scl_in (minimum 2)
STRETCH_EN, 1, 1 = honour slave stretching and clock sync via scl_in; 0 = ignore scl_in entirely

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces IDLE
div_val  input  DIV_WIDTH  half-period length minus 1, in clk cycles
pause  input  1  hold SCL low at the next low phase (TWINT semantics)
scl_in  input  1  raw SCL pad level, asynchronous
scl_oe  output  1  1 = drive SCL low; 0 = release
scl_level  output  1  generated clock level (~scl_oe)
rise_pulse  output  1  one-cycle strobe on entry to HIGH
fall_pulse  output  1  one-cycle strobe on entry to LOW
mid_high_pulse  output  1  one-cycle data-sample strobe in the middle of HIGH
stretch  output  1  1 while SCL is released but the line is still observed low
busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE, cnt=0, div_q=1, all synchroniser flops=1. Outputs: scl_oe=0, scl_level=1, all pulses=0, stretch=0, busy=0.
- scl_sync is the last synchroniser stage. With STRETCH_EN=0, scl_sync is treated as constant 1.
- div_q latches max(div_val,1) on every phase entry (LOW, HIGH). A div_val change mid-phase takes effect at the next phase. div_val=0 behaves as 1.
- cnt resets to 0 on phase entry and increments each cycle. A phase ends in the cycle cnt==div_q, so each LOW/HIGH phase lasts div_q+1 cycles.
- States and outputs:
  - IDLE: scl_oe=0.
  - LOW: scl_oe=1.
  - PARK: scl_oe=1.
  - WAIT_HIGH: scl_oe=0, stretch=1.
  - HIGH: scl_oe=0.
- Transitions:
  - IDLE: en=1 -> LOW, with fall_pulse.
  - LOW at terminal count: pause=1 -> PARK; otherwise -> WAIT_HIGH (STRETCH_EN=0: directly -> HIGH, with rise_pulse).
  - PARK: hold while pause=1; pause=0 -> WAIT_HIGH next cycle.
  - WAIT_HIGH: scl_sync=1 -> HIGH, with rise_pulse. There is no timeout; WAIT_HIGH holds indefinitely.
  - HIGH at terminal count -> LOW, with fall_pulse.
  - HIGH with scl_sync=0 before terminal count (another master pulled SCL low) -> LOW immediately, with fall_pulse and a full low count. This is ignored in the first SYNC_STAGES cycles of HIGH to mask synchroniser lag.
  - mid_high_pulse fires in HIGH when cnt==(div_q>>1). It is suppressed if HIGH was aborted earlier.
- All outputs are registered and decoded from the next-state. Pulses and scl_oe change in the same cycle as the state change.
- en=0 in any state -> IDLE on the next edge: scl_oe=0, cnt=0, no pulses. en has priority over all other events. A pause change is only evaluated at LOW terminal count or in PARK.
- Simultaneous events: en=0 beats everything. In HIGH, terminal count and scl_sync=0 in the same cycle both resolve to LOW with a single fall_pulse.

Test Plan:
- Free run (DIV_WIDTH=8, SYNC_STAGES=2), div_val=4, pause=0, scl_in tied to ~scl_oe -> LOW 5 cycles, WAIT_HIGH 2 cycles (stretch=1), HIGH 5 cycles; period 12 cycles; mid_high_pulse at HIGH cnt=2; pulses exactly 1 cycle wide.
- Pause: assert pause during HIGH, div_val=4 -> HIGH completes, LOW 5 cycles, then PARK with scl_oe=1 indefinitely. Deassert pause -> scl_oe=0 the next cycle, then rise_pulse 2 cycles later.
- Stretch: after LOW ends, hold scl_in=0 for 20 cycles -> stretch=1 and no rise_pulse. rise_pulse occurs 2 cycles after scl_in is released; the HIGH phase is then a full 5 cycles.
- Clock sync: div_val=9; pull scl_in low at HIGH cnt=3 -> fall_pulse and scl_oe=1 two cycles later. LOW lasts 10 cycles; no mid_high_pulse for the aborted HIGH.
- Abort: drop en at LOW cnt=2, and separately assert resetn=0 mid-HIGH -> IDLE (scl_oe=0, busy=0) next edge / immediately. Re-enable -> fall_pulse, fresh LOW of div_q+1 cycles.
- Divider edges: div_val=0 -> 2-cycle phases. Change div_val 4->7 at LOW cnt=1 -> current LOW stays 5 cycles, next HIGH is 8 cycles. STRETCH_EN=0 build with scl_in=0 -> normal free run with no stretch.

Source files
------------

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: programmable SCL generator with pause hold-low,
// slave clock stretching and multi-master clock synchronisation.
module i2c_scl_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_EN  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 pause,
    input  logic                 scl_in,
    output logic                 scl_oe,
    output logic                 scl_level,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 mid_high_pulse,
    output logic                 stretch,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        PARK,
        WAIT_HIGH,
        HIGH
    } state_t;

    localparam int SYNC_W = SYNC_STAGES - 1;
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] MASK_CNT = DIV_WIDTH'(SYNC_STAGES);

    state_t               state;
    state_t               nxt;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_nxt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [SYNC_W-1:0]    sync_q;
    logic                 scl_sync;
    logic                 term;
    logic                 line_lo;
    logic                 oe_nxt;

    // The state register acts as the final synchroniser stage, so a
    // pad change reaches the state SYNC_STAGES edges later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= SYNC_W'({sync_q, scl_in});
        end
    end

    assign scl_sync = (STRETCH_EN != 0) ? sync_q[SYNC_W-1] : 1'b1;
    assign div_eff  = (div_val == '0) ? ONE : div_val;
    assign term     = (cnt == div_q);
    assign line_lo  = !scl_sync && (cnt >= MASK_CNT);

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt + ONE;
        div_nxt = div_q;
        if (!en) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: nxt = LOW;
                LOW: begin
                    if (term) begin
                        if (pause) nxt = PARK;
                        else if (STRETCH_EN != 0) nxt = WAIT_HIGH;
                        else nxt = HIGH;
                    end
                end
                PARK:      if (!pause) nxt = WAIT_HIGH;
                WAIT_HIGH: if (scl_sync) nxt = HIGH;
                HIGH:      if (term || line_lo) nxt = LOW;
                default:   nxt = IDLE;
            endcase
        end
        if ((nxt != state) && ((nxt == LOW) || (nxt == HIGH))) begin
            cnt_nxt = '0;
            div_nxt = div_eff;
        end
        if ((nxt != LOW) && (nxt != HIGH)) begin
            cnt_nxt = '0;
        end
        oe_nxt = (nxt == LOW) || (nxt == PARK);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            div_q          <= ONE;
            scl_oe         <= 1'b0;
            scl_level      <= 1'b1;
            rise_pulse     <= 1'b0;
            fall_pulse     <= 1'b0;
            mid_high_pulse <= 1'b0;
            stretch        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= nxt;
            cnt            <= cnt_nxt;
            div_q          <= div_nxt;
            scl_oe         <= oe_nxt;
            scl_level      <= !oe_nxt;
            rise_pulse     <= (nxt == HIGH) && (state != HIGH);
            fall_pulse     <= (nxt == LOW) && (state != LOW);
            mid_high_pulse <= (nxt == HIGH) && (cnt_nxt == (div_nxt >> 1));
            stretch        <= (nxt == WAIT_HIGH);
            busy           <= (nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: random and directed stimulus for i2c_scl_gen,
// checked every cycle against a phase-length reference model.
module tb_i2c_scl_gen;

    localparam int DW = 8;
    localparam int SY = 2;

    logic          clk;
    logic          resetn = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] div_val = 8'd4;
    logic          pause = 1'b0;
    logic          tie = 1'b1;
    logic          force_v = 1'b1;
    logic          scl_in;
    logic          scl_oe, scl_level, rise_pulse, fall_pulse;
    logic          mid_high_pulse, stretch, busy;
    logic          ns_oe, ns_level, ns_rise, ns_fall, ns_mid;
    logic          ns_stretch, ns_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_mid = 0;
    bit ns_seen = 0;

    assign scl_in = tie ? scl_level : force_v;

    i2c_scl_gen #(.DIV_WIDTH(DW), .SYNC_STAGES(SY), .STRETCH_EN(1)) dut (
        .clk(clk), .resetn(resetn), .en(en), .div_val(div_val),
        .pause(pause), .scl_in(scl_in), .scl_oe(scl_oe),
        .scl_level(scl_level), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .mid_high_pulse(mid_high_pulse),
        .stretch(stretch), .busy(busy)
    );

    i2c_scl_gen #(.DIV_WIDTH(DW), .SYNC_STAGES(SY), .STRETCH_EN(0)) u_ns (
        .clk(clk), .resetn(resetn), .en(en), .div_val(8'd3),
        .pause(1'b0), .scl_in(1'b0), .scl_oe(ns_oe),
        .scl_level(ns_level), .rise_pulse(ns_rise),
        .fall_pulse(ns_fall), .mid_high_pulse(ns_mid),
        .stretch(ns_stretch), .busy(ns_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: phase 0 idle, 1 low, 2 park, 3 wait, 4 high.
    // age is the 1-based cycle number inside a timed phase, plen its length.
    int m_ph = 0;
    int m_age = 0;
    int m_plen = 2;
    bit m_rise = 0;
    bit m_fall = 0;
    bit m_mid = 0;
    bit sh [SY-1];
    bit seen;

    function automatic int plen_of(input int d);
        return ((d == 0) ? 1 : d) + 1;
    endfunction

    task automatic go_low();
        m_ph = 1;
        m_age = 1;
        m_plen = plen_of(int'(div_val));
        m_fall = 1;
    endtask

    task automatic go_high();
        m_ph = 4;
        m_age = 1;
        m_plen = plen_of(int'(div_val));
        m_rise = 1;
        if ((m_plen - 1) / 2 == 0) m_mid = 1;
    endtask

    initial begin
        foreach (sh[i]) sh[i] = 1;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_ph = 0; m_age = 0; m_plen = 2;
                m_rise = 0; m_fall = 0; m_mid = 0;
                foreach (sh[i]) sh[i] = 1;
            end else begin
                seen = sh[SY-2];
                for (int i = SY - 2; i > 0; i--) sh[i] = sh[i-1];
                sh[0] = scl_in;
                m_rise = 0; m_fall = 0; m_mid = 0;
                if (!en) begin
                    m_ph = 0;
                end else begin
                    case (m_ph)
                        0: go_low();
                        1: begin
                            if (m_age == m_plen) m_ph = pause ? 2 : 3;
                            else m_age++;
                        end
                        2: if (!pause) m_ph = 3;
                        3: if (seen) go_high();
                        4: begin
                            if (m_age == m_plen || (!seen && m_age > SY)) begin
                                go_low();
                            end else begin
                                m_age++;
                                if (m_age - 1 == (m_plen - 1) / 2) m_mid = 1;
                            end
                        end
                        default: m_ph = 0;
                    endcase
                end
            end
        end
    end

    logic [6:0] dut_v, exp_v;
    bit m_oe;
    assign dut_v = {scl_oe, scl_level, rise_pulse, fall_pulse,
                    mid_high_pulse, stretch, busy};

    initial forever begin
        @(negedge clk);
        m_oe = (m_ph == 1) || (m_ph == 2);
        exp_v = {m_oe, !m_oe, m_rise, m_fall, m_mid, m_ph == 3, m_ph != 0};
        checks++;
        if (dut_v !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d outputs got %b expected %b",
                     cyc, dut_v, exp_v);
        end
        if (mid_high_pulse) n_mid++;
        if (ns_stretch) ns_seen = 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit sel(input int which);
        case (which)
            0: return rise_pulse;
            1: return fall_pulse;
            2: return mid_high_pulse;
            3: return ns_rise;
            default: return ns_fall;
        endcase
    endfunction

    // Returns the cycle of the next strobe, or -1 when the bound expires.
    task automatic wait_pulse(input int which, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit && t < 0; i++) begin
            @(negedge clk);
            if (sel(which)) t = cyc;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int tf, tr, tm, tf2, tr2, c, t, m0, a, b, r;

    initial begin
        tick(2);
        chk("rst_oe", int'(scl_oe), 0);
        chk("rst_level", int'(scl_level), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'({rise_pulse, fall_pulse, mid_high_pulse}), 0);
        #2 resetn = 1'b1;
        @(negedge clk);
        en = 1'b1;

        wait_pulse(1, 20, tf);
        wait_pulse(0, 20, tr);
        chk("free_low_wait", tr - tf, 7);
        wait_pulse(2, 20, tm);
        chk("free_mid", tm - tr, 2);
        wait_pulse(1, 20, tf2);
        chk("free_high", tf2 - tr, 5);
        wait_pulse(0, 20, tr2);
        chk("free_period", tr2 - tr, 12);

        wait_pulse(3, 20, a);
        wait_pulse(3, 20, b);
        chk("ns_period", b - a, 8);
        wait_pulse(0, 20, tr2);

        pause = 1'b1;
        wait_pulse(1, 20, tf);
        chk("pause_high", tf - tr2, 5);
        wait_pulse(0, 30, t);
        chk("park_norise", t, -1);
        chk("park_oe", int'(scl_oe), 1);
        pause = 1'b0;
        c = cyc;
        @(negedge clk);
        chk("park_rel_oe", int'(scl_oe), 0);
        wait_pulse(0, 10, tr);
        chk("park_rise", tr - c, 3);

        wait_pulse(1, 20, tf);
        tick(2);
        tie = 1'b0;
        force_v = 1'b0;
        wait_pulse(0, 20, t);
        chk("stretch_norise", t, -1);
        chk("stretch_flag", int'(stretch), 1);
        c = cyc;
        tie = 1'b1;
        wait_pulse(0, 10, tr);
        chk("stretch_rise", tr - c, 2);
        wait_pulse(1, 20, tf);
        chk("stretch_high", tf - tr, 5);

        div_val = 8'd9;
        wait_pulse(0, 20, tr);
        tick(3);
        tie = 1'b0;
        force_v = 1'b0;
        c = cyc;
        wait_pulse(1, 10, tf);
        chk("sync_fall", tf - c, 2);
        tie = 1'b1;
        wait_pulse(0, 30, tr);
        chk("sync_low", tr - tf, 12);
        m0 = n_mid;
        tick(1);
        tie = 1'b0;
        wait_pulse(1, 10, tf);
        chk("sync_early_fall", tf - tr, 3);
        chk("sync_nomid", n_mid - m0, 0);
        tie = 1'b1;

        div_val = 8'd4;
        tick(2);
        en = 1'b0;
        @(negedge clk);
        chk("abort_oe", int'(scl_oe), 0);
        chk("abort_busy", int'(busy), 0);
        tick(1);
        en = 1'b1;
        c = cyc;
        wait_pulse(1, 5, tf);
        chk("reen_fall", tf - c, 1);
        wait_pulse(0, 20, tr);
        chk("reen_low", tr - tf, 7);
        tick(1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_oe", int'(scl_oe), 0);
        chk("rst_mid_busy", int'(busy), 0);
        @(negedge clk);
        c = cyc;
        #2 resetn = 1'b1;
        wait_pulse(1, 5, tf);
        chk("rst_rel_fall", tf - c, 1);
        wait_pulse(0, 20, tr);
        chk("rst_rel_low", tr - tf, 7);

        div_val = 8'd0;
        wait_pulse(1, 20, tf);
        wait_pulse(0, 20, tr);
        chk("div0_low_wait", tr - tf, 4);
        wait_pulse(0, 20, tr2);
        chk("div0_period", tr2 - tr, 6);
        div_val = 8'd4;
        wait_pulse(1, 20, tf);
        tick(1);
        div_val = 8'd7;
        wait_pulse(0, 20, tr);
        chk("divchg_low", tr - tf, 7);
        wait_pulse(1, 20, tf2);
        chk("divchg_high", tf2 - tr, 8);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) pause = !pause;
            if ($urandom_range(0, 99) < 2) div_val = 8'($urandom_range(0, 6));
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                tie = 1'b0;
                force_v = 1'($urandom_range(0, 1));
            end else if (r < 10) begin
                tie = 1'b1;
            end
            if (en) begin
                if ($urandom_range(0, 199) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end
            if (i % 800 == 400) begin
                #2 resetn = 1'b0;
                @(negedge clk);
                #2 resetn = 1'b1;
            end
        end

        chk("ns_no_stretch", int'(ns_seen), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
